tic_tac_toe_move_picker: RTL and testbench

- Computer-move generator upstream of tic_tac_toe_game.
- On request, snapshots the current board (pos1..pos9, who) and runs a multi-cycle rule scan: win, then block, then centre, then corner, then first free.
- Drives computer_position and a pc strobe directly into the game's pc/computer_position inputs.
- Sequential scan, one rule candidate per cycle, keeps the logic small and deterministic for the bench.

---
 rtl/ttt_pkg.sv | 52 +++++
 rtl/ttt_line_check.sv | 50 +++++
 rtl/tic_tac_toe_move_picker.sv | 231 +++++++++++++++++++++++
 tb/tb_tic_tac_toe_move_picker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe computer-move picker:
//   - cell encodings as driven by the game (00 empty, 01 player, 10 computer)
//   - game-result (who) encodings
//   - the eight winning lines as a fixed 8x3 table of 0-based cell indices
//   - the corner visiting order
//   - the picker FSM state enum
// ----------------------------------------------------------------------------
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY    = 2'b00;
   localparam logic [1:0] CELL_PLAYER   = 2'b01;
   localparam logic [1:0] CELL_COMPUTER = 2'b10;

   localparam logic [1:0] WHO_PLAYING      = 2'b00;
   localparam logic [1:0] WHO_PLAYER_WON   = 2'b01;
   localparam logic [1:0] WHO_COMPUTER_WON = 2'b10;
   localparam logic [1:0] WHO_DRAW         = 2'b11;

   localparam int NUM_CELLS   = 9;
   localparam int NUM_LINES   = 8;
   localparam int NUM_CORNERS = 4;

   // Rows, then columns, then the two diagonals. Order decides priority
   // when several lines hit.
   localparam logic [3:0] LINE_TBL [0:NUM_LINES-1][0:2] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   localparam logic [3:0] CORNER_TBL [0:NUM_CORNERS-1] = '{4'd0, 4'd2, 4'd6, 4'd8};

   localparam logic [3:0] CENTER_CELL = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN_WIN,
      ST_SCAN_BLOCK,
      ST_PICK_CENTER,
      ST_SCAN_CORNER,
      ST_SCAN_ANY,
      ST_ISSUE
   } state_e;

endpackage

// File: rtl/ttt_line_check.sv
// ----------------------------------------------------------------------------
// ttt_line_check
// Combinational check of one three-cell line: hit is high when exactly two
// cells equal target and the remaining cell is empty; empty_idx then names
// that empty cell. The target is never the empty code, so a "match" and an
// "empty" are mutually exclusive per cell.
// Ports:
//   c0..c2      in   2  cell contents of the line
//   target      in   2  occupant code being looked for (computer or player)
//   i0..i2      in   4  0-based board indices of c0..c2
//   hit         out  1  two-of-target plus one empty
//   empty_idx   out  4  index of the empty cell (meaningful only on hit)
// ----------------------------------------------------------------------------
module ttt_line_check
   import ttt_pkg::*;
(
   input  logic [1:0] c0,
   input  logic [1:0] c1,
   input  logic [1:0] c2,
   input  logic [1:0] target,
   input  logic [3:0] i0,
   input  logic [3:0] i1,
   input  logic [3:0] i2,
   output logic       hit,
   output logic [3:0] empty_idx
);

   logic m0, m1, m2;
   logic e0, e1, e2;

   always_comb begin
      m0 = (c0 == target);
      m1 = (c1 == target);
      m2 = (c2 == target);
      e0 = (c0 == CELL_EMPTY);
      e1 = (c1 == CELL_EMPTY);
      e2 = (c2 == CELL_EMPTY);

      hit = (m0 & m1 & e2) | (m0 & e1 & m2) | (e0 & m1 & m2);

      if (e0) begin
         empty_idx = i0;
      end else if (e1) begin
         empty_idx = i1;
      end else begin
         empty_idx = i2;
      end
   end

endmodule

// File: rtl/tic_tac_toe_move_picker.sv
// ----------------------------------------------------------------------------
// tic_tac_toe_move_picker
// Computer-move generator feeding the game's pc/computer_position inputs.
// On an accepted request the board is snapshotted and scanned one candidate
// per cycle: win line, block line, centre, corners (0,2,6,8), any free cell.
// The chosen cell is registered on entry to ISSUE; pc then rises on the next
// edge and stays high for PC_HOLD cycles.
// Ports:
//   clock              in   1  system clock, rising edge
//   reset              in   1  synchronous, active-low reset
//   move_req           in   1  request a move (sampled only in IDLE)
//   pos1..pos9         in   2  board cells from the game
//   who                in   2  game result; requests rejected unless 00
//   computer_position  out  4  chosen cell, 0-based
//   pc                 out  1  move strobe, high PC_HOLD cycles
//   busy               out  1  high from acceptance until back in IDLE
//   no_move            out  1  one-cycle pulse: rejected or board full
// ----------------------------------------------------------------------------
module tic_tac_toe_move_picker
   import ttt_pkg::*;
#(
   parameter int unsigned PC_HOLD = 1
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       move_req,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic [1:0] who,
   output logic [3:0] computer_position,
   output logic       pc,
   output logic       busy,
   output logic       no_move
);

   localparam logic [3:0] HOLD_LAST = 4'(PC_HOLD);

   state_e     state_q, state_d;
   logic [3:0] step_q, step_d;
   logic [3:0] hold_q, hold_d;
   logic [3:0] cpos_q, cpos_d;
   logic       pc_q, pc_d;
   logic       busy_q, busy_d;
   logic       no_move_q, no_move_d;
   logic [1:0] board_q [0:NUM_CELLS-1];
   logic [1:0] board_d [0:NUM_CELLS-1];

   logic [1:0] pos_in [0:NUM_CELLS-1];

   // Line-check wiring, shared by the win and block scans.
   logic [3:0] li0, li1, li2;
   logic [1:0] lc0, lc1, lc2;
   logic [1:0] line_target;
   logic       line_hit;
   logic [3:0] line_empty_idx;
   logic [1:0] corner_cell;
   logic [1:0] any_cell;

   assign pos_in[0] = pos1;
   assign pos_in[1] = pos2;
   assign pos_in[2] = pos3;
   assign pos_in[3] = pos4;
   assign pos_in[4] = pos5;
   assign pos_in[5] = pos6;
   assign pos_in[6] = pos7;
   assign pos_in[7] = pos8;
   assign pos_in[8] = pos9;

   always_comb begin
      li0         = LINE_TBL[step_q[2:0]][0];
      li1         = LINE_TBL[step_q[2:0]][1];
      li2         = LINE_TBL[step_q[2:0]][2];
      lc0         = board_q[li0];
      lc1         = board_q[li1];
      lc2         = board_q[li2];
      line_target = (state_q == ST_SCAN_BLOCK) ? CELL_PLAYER : CELL_COMPUTER;
      corner_cell = board_q[CORNER_TBL[step_q[1:0]]];
      // step_q never exceeds 8 while in SCAN_ANY; clamp anyway so other
      // states cannot read past the board.
      any_cell    = (step_q <= 4'd8) ? board_q[step_q] : CELL_EMPTY;
   end

   ttt_line_check u_line_check (
      .c0        (lc0),
      .c1        (lc1),
      .c2        (lc2),
      .target    (line_target),
      .i0        (li0),
      .i1        (li1),
      .i2        (li2),
      .hit       (line_hit),
      .empty_idx (line_empty_idx)
   );

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      hold_d    = hold_q;
      cpos_d    = cpos_q;
      pc_d      = 1'b0;
      busy_d    = busy_q;
      no_move_d = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         board_d[i] = board_q[i];
      end

      unique case (state_q)
         ST_IDLE: begin
            if (move_req) begin
               if (who != WHO_PLAYING) begin
                  no_move_d = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_CELLS; i++) begin
                     board_d[i] = pos_in[i];
                  end
                  busy_d  = 1'b1;
                  step_d  = 4'd0;
                  state_d = ST_SCAN_WIN;
               end
            end
         end

         ST_SCAN_WIN, ST_SCAN_BLOCK: begin
            if (line_hit) begin
               cpos_d  = line_empty_idx;
               hold_d  = 4'd0;
               state_d = ST_ISSUE;
            end else if (step_q == 4'(NUM_LINES - 1)) begin
               step_d  = 4'd0;
               state_d = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PICK_CENTER;
            end else begin
               step_d = step_q + 4'd1;
            end
         end

         ST_PICK_CENTER: begin
            if (board_q[CENTER_CELL] == CELL_EMPTY) begin
               cpos_d  = CENTER_CELL;
               hold_d  = 4'd0;
               state_d = ST_ISSUE;
            end else begin
               step_d  = 4'd0;
               state_d = ST_SCAN_CORNER;
            end
         end

         ST_SCAN_CORNER: begin
            if (corner_cell == CELL_EMPTY) begin
               cpos_d  = CORNER_TBL[step_q[1:0]];
               hold_d  = 4'd0;
               state_d = ST_ISSUE;
            end else if (step_q == 4'(NUM_CORNERS - 1)) begin
               step_d  = 4'd0;
               state_d = ST_SCAN_ANY;
            end else begin
               step_d = step_q + 4'd1;
            end
         end

         ST_SCAN_ANY: begin
            if (any_cell == CELL_EMPTY) begin
               cpos_d  = step_q;
               hold_d  = 4'd0;
               state_d = ST_ISSUE;
            end else if (step_q == 4'(NUM_CELLS - 1)) begin
               no_move_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               step_d = step_q + 4'd1;
            end
         end

         ST_ISSUE: begin
            // First cycle in ISSUE has pc low; pc rises on the following
            // edge and is counted until PC_HOLD cycles have elapsed.
            if (hold_q == HOLD_LAST) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               pc_d   = 1'b1;
               hold_d = hold_q + 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         step_q    <= 4'd0;
         hold_q    <= 4'd0;
         cpos_q    <= 4'd0;
         pc_q      <= 1'b0;
         busy_q    <= 1'b0;
         no_move_q <= 1'b0;
         for (int i = 0; i < NUM_CELLS; i++) begin
            board_q[i] <= CELL_EMPTY;
         end
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         hold_q    <= hold_d;
         cpos_q    <= cpos_d;
         pc_q      <= pc_d;
         busy_q    <= busy_d;
         no_move_q <= no_move_d;
         for (int i = 0; i < NUM_CELLS; i++) begin
            board_q[i] <= board_d[i];
         end
      end
   end

   assign computer_position = cpos_q;
   assign pc                = pc_q;
   assign busy              = busy_q;
   assign no_move           = no_move_q;

endmodule

// File: tb/tb_tic_tac_toe_move_picker.sv
// ----------------------------------------------------------------------------
// tb_tic_tac_toe_move_picker
// Directed bench for the move picker. Edge 0 is the edge that samples
// move_req; outputs are sampled on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_tic_tac_toe_move_picker;

   localparam int PC_HOLD = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       move_req = 1'b0;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [1:0] who = 2'b00;
   logic [3:0] computer_position;
   logic       pc;
   logic       busy;
   logic       no_move;

   int checks = 0;
   int errors = 0;

   tic_tac_toe_move_picker #(.PC_HOLD(PC_HOLD)) dut (
      .clock             (clock),
      .reset             (reset),
      .move_req          (move_req),
      .pos1              (pos1),
      .pos2              (pos2),
      .pos3              (pos3),
      .pos4              (pos4),
      .pos5              (pos5),
      .pos6              (pos6),
      .pos7              (pos7),
      .pos8              (pos8),
      .pos9              (pos9),
      .who               (who),
      .computer_position (computer_position),
      .pc                (pc),
      .busy              (busy),
      .no_move           (no_move)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_board(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                            input logic [1:0] a4, input logic [1:0] a5, input logic [1:0] a6,
                            input logic [1:0] a7, input logic [1:0] a8, input logic [1:0] a9);
      pos1 = a1; pos2 = a2; pos3 = a3;
      pos4 = a4; pos5 = a5; pos6 = a6;
      pos7 = a7; pos8 = a8; pos9 = a9;
   endtask

   // Issue a request, scramble the board inputs (must be ignored after the
   // snapshot), optionally pulse a second request at edge extra_at, then
   // check pc latency (exp_n + 1), the chosen cell and the pc width.
   task automatic do_move(input string tag, input int exp_n, input logic [3:0] exp_cp,
                          input int extra_at);
      int edges;
      bit seen;
      int hi;
      @(negedge clock);
      move_req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      move_req = 1'b0;
      set_board(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
      check({tag, "_busy_on_accept"}, busy, 1);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 60) begin
         @(posedge clock);
         edges++;
         @(negedge clock);
         move_req = (edges == extra_at);
         if (pc) seen = 1'b1;
      end
      move_req = 1'b0;
      check({tag, "_pc_edge"}, edges, exp_n + 1);
      check({tag, "_position"}, computer_position, exp_cp);
      check({tag, "_busy_during_pc"}, busy, 1);
      hi = 0;
      while (pc && hi < 40) begin
         hi++;
         @(posedge clock);
         @(negedge clock);
      end
      check({tag, "_pc_width"}, hi, PC_HOLD);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_position_hold"}, computer_position, exp_cp);
      $display("move %s: pc_edge=%0d position=%0d pc_width=%0d", tag, edges, computer_position, hi);
   endtask

   initial begin : stim
      int  edges;
      bit  pc_seen;

      set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_pc", pc, 0);
      check("reset_busy", busy, 0);
      check("reset_no_move", no_move, 0);
      check("reset_position", computer_position, 0);
      reset = 1'b1;
      $display("reset: pc=%0d busy=%0d no_move=%0d position=%0d", pc, busy, no_move, computer_position);

      // Win beats block: computer at 0,1; player at 3,4 -> line 0, cell 2, N=1
      set_board(2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      do_move("win", 1, 4'd2, -1);

      // Full board with no winner: no_move at edge 30, pc stays low
      set_board(2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10);
      @(negedge clock);
      move_req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      move_req = 1'b0;
      edges   = 0;
      pc_seen = 1'b0;
      while (!no_move && edges < 60) begin
         @(posedge clock);
         edges++;
         @(negedge clock);
         if (pc) pc_seen = 1'b1;
      end
      check("full_no_move_edge", edges, 30);
      check("full_pc_never", pc_seen, 0);
      check("full_busy_low", busy, 0);
      check("full_position_kept", computer_position, 2);
      @(posedge clock);
      @(negedge clock);
      check("full_no_move_pulse", no_move, 0);
      $display("full board: no_move_edge=%0d pc_seen=%0d position=%0d", edges, pc_seen, computer_position);

      // Game already over: request rejected on the next edge
      who = 2'b01;
      set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clock);
      move_req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      move_req = 1'b0;
      check("reject_no_move", no_move, 1);
      check("reject_busy", busy, 0);
      @(posedge clock);
      @(negedge clock);
      check("reject_no_move_clear", no_move, 0);
      check("reject_busy_still_low", busy, 0);
      $display("reject: no_move cleared=%0d busy=%0d", no_move, busy);
      who = 2'b00;

      // Block on line 1 (N=10, cell 5) with a second request mid-scan
      set_board(2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      do_move("block", 10, 4'd5, 4);

      // Empty board -> centre, N=17
      set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      do_move("centre", 17, 4'd4, -1);

      // Reset during SCAN_BLOCK (edges 9..16) abandons the move
      set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      @(negedge clock);
      move_req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      move_req = 1'b0;
      repeat (11) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      check("midreset_busy", busy, 0);
      check("midreset_pc", pc, 0);
      check("midreset_position", computer_position, 0);
      pc_seen = 1'b0;
      repeat (25) begin
         @(posedge clock);
         @(negedge clock);
         if (pc || busy) pc_seen = 1'b1;
      end
      check("midreset_abandoned", pc_seen, 0);
      $display("mid-scan reset: busy=%0d pc=%0d position=%0d", busy, pc, computer_position);

      // Centre taken, corner 0 taken by computer -> corner 2, N=19
      set_board(2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      do_move("corner2", 19, 4'd2, -1);

      // Centre taken by player, rest empty -> corner 0, N=18
      set_board(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
      do_move("corner0", 18, 4'd0, -1);

      // Centre and corners hold 11 (occupied); first free is cell 1, N=23
      set_board(2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11);
      do_move("any", 23, 4'd1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
